// File: rtl/sam_arb_pkg.sv
// ---------------------------------------------------------------------------
// sam_arb_pkg
// Shared types and defaults for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, IF_ACT, DM_ACT)
//   arb_owner_t : owner of a transaction (OWN_IF, OWN_DM)
//   DEF_DATA_W  : default address/data width
//   DEF_TIMEOUT : default number of active cycles before an abort
//   act_state() : maps a winning owner to its active state
// ---------------------------------------------------------------------------
package sam_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACT = 2'd1,
    ST_DM_ACT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  function automatic arb_state_t act_state(input arb_owner_t own);
    return (own == OWN_DM) ? ST_DM_ACT : ST_IF_ACT;
  endfunction

endpackage

// File: rtl/sam_arb_timer.sv
// ---------------------------------------------------------------------------
// sam_arb_timer
// Counts active cycles of the current memory transaction and flags the
// cycle in which the TIMEOUT-th active cycle is reached without an ack.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : synchronous clear (held while the arbiter is idle)
//   enable  : count this cycle (arbiter has a transaction outstanding)
//   expired : combinational, high during the TIMEOUT-th enabled cycle
// ---------------------------------------------------------------------------
module sam_arb_timer
  import sam_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The counter holds (active cycles already elapsed), so it only needs to
  // reach TIMEOUT-1: the expiring cycle is flagged before it would wrap.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sam_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sam_mem_arbiter
// Arbitrates an instruction-fetch port and a data-memory port onto a single
// memory interface with at most one transaction outstanding. Requests whose
// memory does not acknowledge within TIMEOUT active cycles are aborted and
// answered with rsp_err=1.
//
// Configuration macro
//   SAM_ARB_RR_EN : when defined, contention alternates between IF and DM
//                   using a last_owner register; otherwise DM always wins.
//
// Handshake
//   *_req is held by the requester until *_gnt is seen high. *_gnt is a
//   combinational one-cycle pulse, only possible while IDLE; the request
//   fields are captured on the clock edge that ends the grant cycle. The
//   response is a one-cycle *_rvalid pulse with rsp_rdata/rsp_err valid in
//   the same cycle. mem_req is held with stable mem_* fields until mem_ack
//   (single-cycle, mem_rdata valid with it) or the timeout.
//
// Ports
//   clk, RN                    : clock, asynchronous active-high reset
//   if_req/if_addr             : fetch request (read only)
//   if_gnt/if_rvalid           : fetch accept / fetch response
//   dm_req/we/addr/wdata/be    : data request
//   dm_gnt/dm_rvalid           : data accept / data response
//   rsp_rdata/rsp_err          : shared response data / timeout flag
//   mem_req/we/addr/wdata/be   : registered memory request
//   mem_rdata/mem_ack          : memory read data / completion
//   dbg_state                  : current FSM state
// ---------------------------------------------------------------------------
module sam_mem_arbiter
  import sam_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                RN,
  // instruction fetch port
  input  logic                if_req,
  input  logic [DATA_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  // data memory port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  // shared response
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  // debug
  output logic [1:0]          dbg_state
);

  arb_state_t state;
  arb_owner_t win_owner;
  logic       pick_dm;
  logic       can_grant;
  logic       grant_if;
  logic       grant_dm;
  logic       active;
  logic       timer_expired;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef SAM_ARB_RR_EN
  arb_owner_t last_owner;

  // On contention the requester that was not served last wins.
  assign pick_dm = dm_req && (!if_req || (last_owner == OWN_IF));

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      last_owner <= OWN_DM;
    end else if (grant_if || grant_dm) begin
      last_owner <= win_owner;
    end
  end
`else
  // Fixed priority: data accesses always beat instruction fetches.
  assign pick_dm = dm_req;
`endif

  // RN gates the grants so every output is low while reset is held, even
  // though the grant path is combinational from the request inputs.
  assign can_grant = (state == ST_IDLE) && !RN;
  assign grant_dm  = can_grant && pick_dm;
  assign grant_if  = can_grant && if_req && !pick_dm;
  assign win_owner = pick_dm ? OWN_DM : OWN_IF;

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Timeout counter: runs only while a transaction is outstanding and is
  // held cleared in IDLE so each transaction starts from zero.
  // -------------------------------------------------------------------------
  assign active = (state == ST_IF_ACT) || (state == ST_DM_ACT);

  sam_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (RN),
    .clear   (!active),
    .enable  (active),
    .expired (timer_expired)
  );

  // -------------------------------------------------------------------------
  // FSM with registered memory request and registered responses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses.
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      rsp_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          // mem_ack arriving here belongs to nothing and is ignored.
          if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            state     <= act_state(win_owner);
          end else if (grant_if) begin
            // Fetches are reads with no write payload.
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '0;
            state     <= act_state(win_owner);
          end
        end

        ST_IF_ACT, ST_DM_ACT: begin
          // An ack in the expiring cycle still completes normally, so the
          // ack branch is checked first.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rsp_rdata <= mem_we ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
            if (state == ST_DM_ACT) begin
              dm_rvalid <= 1'b1;
            end else begin
              if_rvalid <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (timer_expired) begin
            mem_req   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            if (state == ST_DM_ACT) begin
              dm_rvalid <= 1'b1;
            end else begin
              if_rvalid <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sam_mem_arbiter
// Self-checking bench for sam_mem_arbiter. A negedge scoreboard predicts
// grants, memory-side fields and responses from the arbitration and timeout
// rules; scenario tasks add directed checks on latency and data.
// ---------------------------------------------------------------------------
module tb_sam_mem_arbiter;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 15;
`ifdef SAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RN  = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic          if_req = 1'b0;
  logic [DW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [DW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [1:0]    dbg_state;

  sam_mem_arbiter #(
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .RN        (RN),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  // ack_lat = k acks in the k-th cycle mem_req is high; 0 means never.
  int  ack_lat   = 1;
  bit  stray_ack = 1'b0;
  int  act_cnt   = 0;
  logic [DW-1:0] mem_arr [logic [DW-1:0]];

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (mem_req === 1'b1) act_cnt++;
    else act_cnt = 0;
    if (mem_req === 1'b1 && ack_lat != 0 && act_cnt == ack_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
    end else begin
      mem_ack   = stray_ack;
      mem_rdata = $urandom();
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            exp_err_q[$];
  bit            exp_dm_q[$];
  bit            pend = 1'b0;
  int            pend_due = 0;
  logic          pend_we;
  logic [DW-1:0] pend_addr, pend_wdata;
  logic [BW-1:0] pend_be;
  bit            m_last_dm = 1'b1;
  bit            m_busy, eg_if, eg_dm, e_err, e_dm;
  logic [DW-1:0] e_rd;

  always @(negedge clk) begin
    if (RN === 1'b1) begin
      checks++;
      if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, rsp_err} !== 7'd0 ||
          rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_be !== '0 ||
          dbg_state !== 2'd0)
        begin
          errors++;
          $display("FAIL reset_outputs @%0d: gnt=%b/%b rv=%b/%b mem_req=%b rdata=%h expected all zero",
                   cyc, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, rsp_rdata);
        end
      pend = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      exp_dm_q.delete();
      m_last_dm = 1'b1;
    end else begin
      m_busy = pend && (cyc < pend_due);
      // DM wins unless IF also requests and rotation says IF's turn.
      eg_dm = !m_busy && dm_req && (!if_req || !RR || !m_last_dm);
      eg_if = !m_busy && if_req && !eg_dm;

      checks++;
      if (if_gnt !== eg_if || dm_gnt !== eg_dm) begin
        errors++;
        $display("FAIL grant @%0d: if_gnt=%b dm_gnt=%b expected %b %b", cyc, if_gnt, dm_gnt, eg_if, eg_dm);
      end
      checks++;
      if (mem_req !== m_busy) begin
        errors++;
        $display("FAIL mem_req @%0d: got %b expected %b", cyc, mem_req, m_busy);
      end
      if (m_busy) begin
        checks++;
        if (mem_addr !== pend_addr || mem_we !== pend_we || mem_wdata !== pend_wdata || mem_be !== pend_be) begin
          errors++;
          $display("FAIL mem_fields @%0d: got a=%h we=%b wd=%h be=%b expected a=%h we=%b wd=%h be=%b",
                   cyc, mem_addr, mem_we, mem_wdata, mem_be, pend_addr, pend_we, pend_wdata, pend_be);
        end
      end
      if (pend && cyc == pend_due) begin
        e_rd  = exp_q.pop_front();
        e_err = exp_err_q.pop_front();
        e_dm  = exp_dm_q.pop_front();
        checks++;
        if (dm_rvalid !== e_dm || if_rvalid !== !e_dm || rsp_rdata !== e_rd || rsp_err !== e_err) begin
          errors++;
          $display("FAIL response @%0d: rv if/dm=%b/%b rdata=%h err=%b expected dm=%b rdata=%h err=%b",
                   cyc, if_rvalid, dm_rvalid, rsp_rdata, rsp_err, e_dm, e_rd, e_err);
        end
        pend = 1'b0;
      end else begin
        checks++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL spurious_rvalid @%0d: if=%b dm=%b expected 0 0", cyc, if_rvalid, dm_rvalid);
        end
      end
      if (eg_dm || eg_if) begin
        pend       = 1'b1;
        m_last_dm  = eg_dm;
        pend_we    = eg_dm ? dm_we : 1'b0;
        pend_addr  = eg_dm ? dm_addr : if_addr;
        pend_wdata = eg_dm ? dm_wdata : '0;
        pend_be    = eg_dm ? dm_be : '0;
        if (ack_lat >= 1 && ack_lat <= TO) begin
          pend_due = cyc + 1 + ack_lat;
          exp_q.push_back(pend_we ? '0 : mem_word(pend_addr));
          exp_err_q.push_back(1'b0);
        end else begin
          pend_due = cyc + 1 + TO;
          exp_q.push_back('0);
          exp_err_q.push_back(1'b1);
        end
        exp_dm_q.push_back(eg_dm);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_if(input logic [DW-1:0] a, output int gc, output bit ok);
    ok = 1'b0;
    gc = -1;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_gnt === 1'b1) begin
        gc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if_req  = 1'b0;
    if_addr = $urandom();
  endtask

  task automatic issue_dm(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be, output int gc, output bit ok);
    ok = 1'b0;
    gc = -1;
    @(posedge clk); #1;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_be    = be;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_gnt === 1'b1) begin
        gc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    dm_req   = 1'b0;
    dm_addr  = $urandom();
    dm_wdata = $urandom();
  endtask

  task automatic wait_rsp(input bit dm, output int rc, output logic [DW-1:0] rd,
                          output logic er, output bit ok);
    ok = 1'b0;
    rc = -1;
    rd = 'x;
    er = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((dm ? dm_rvalid : if_rvalid) === 1'b1) begin
        rc = cyc;
        rd = rsp_rdata;
        er = rsp_err;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    RN     = 1'b1;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_req !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b/%b mem_req=%b state=%0d expected 0", if_gnt, dm_gnt, mem_req, dbg_state);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clk); #1;
    RN = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d mem_req=%b expected 0 0", dbg_state, mem_req);
    end
  endtask

  task automatic test_load();
    int g, rc;
    bit ok, okr;
    logic [DW-1:0] rd;
    logic er;
    mem_arr[32'h100] = 32'hDEADBEEF;
    ack_lat = 1;
    issue_dm(1'b0, 32'h100, 32'h0, 4'hF, g, ok);
    wait_rsp(1'b1, rc, rd, er, okr);
    checks++;
    if (!ok || !okr || rc != g + 2) begin
      errors++;
      $display("FAIL load_latency: gnt@%0d rvalid@%0d (ok=%b/%b) expected rvalid at gnt+2", g, rc, ok, okr);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL load_data: rdata=%h err=%b expected deadbeef 0", rd, er);
    end
  endtask

  task automatic test_store();
    int g, rc, held;
    bit ok, okr;
    logic [DW-1:0] rd;
    logic er;
    ack_lat = 4;
    held = 0;
    issue_dm(1'b1, 32'h200, 32'h1234, 4'b0011, g, ok);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_be === 4'b0011 && mem_wdata === 32'h1234) held++;
    end
    checks++;
    if (held != 4) begin
      errors++;
      $display("FAIL store_fields: stable cycles=%0d expected 4", held);
    end
    wait_rsp(1'b1, rc, rd, er, okr);
    checks++;
    if (!ok || !okr || rc != g + 5 || rd !== '0 || er !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: gnt@%0d rv@%0d rdata=%h err=%b expected rv at gnt+5 rdata 0 err 0",
               g, rc, rd, er);
    end
  endtask

  task automatic test_contention();
    int gd, gi, rcd, rci;
    bit okd, oki, okrd, okri, exp_first_dm, first_dm;
    logic [DW-1:0] rdd, rdi;
    logic erd, eri;
    ack_lat = 1;
    exp_first_dm = !RR || !m_last_dm;
    fork
      begin
        issue_dm(1'b0, 32'h340, 32'h0, 4'hF, gd, okd);
        wait_rsp(1'b1, rcd, rdd, erd, okrd);
      end
      begin
        issue_if(32'h380, gi, oki);
        wait_rsp(1'b0, rci, rdi, eri, okri);
      end
    join
    first_dm = (gd < gi);
    checks++;
    if (!okd || !oki || !okrd || !okri || first_dm != exp_first_dm) begin
      errors++;
      $display("FAIL contention_order: dm_gnt@%0d if_gnt@%0d expected dm_first=%b", gd, gi, exp_first_dm);
    end
    checks++;
    if ((first_dm ? gi : gd) != (first_dm ? rcd : rci)) begin
      errors++;
      $display("FAIL contention_regrant: second gnt@%0d first rvalid@%0d expected equal",
               first_dm ? gi : gd, first_dm ? rcd : rci);
    end
    checks++;
    if (rdd !== mem_word(32'h340) || rdi !== mem_word(32'h380) || erd !== 1'b0 || eri !== 1'b0) begin
      errors++;
      $display("FAIL contention_data: dm=%h if=%h expected %h %h", rdd, rdi, mem_word(32'h340), mem_word(32'h380));
    end
  endtask

  task automatic test_timeout();
    int g, rc, held;
    bit ok, seen;
    logic [DW-1:0] rd;
    logic er;
    ack_lat = 0;
    held = 0;
    seen = 1'b0;
    rc = -1;
    rd = 'x;
    er = 1'bx;
    issue_if(32'h300, g, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_rvalid === 1'b1) begin
        rc = cyc;
        rd = rsp_rdata;
        er = rsp_err;
        seen = 1'b1;
        break;
      end
      if (mem_req === 1'b1) held++;
    end
    checks++;
    if (!ok || !seen || held != TO || rc != g + 1 + TO) begin
      errors++;
      $display("FAIL timeout_timing: mem_req cycles=%0d rv@%0d gnt@%0d expected %0d cycles rv at gnt+%0d",
               held, rc, g, TO, TO + 1);
    end
    checks++;
    if (er !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL timeout_resp: err=%b rdata=%h expected 1 0", er, rd);
    end
    ack_lat = TO;
    issue_if(32'h304, g, ok);
    wait_rsp(1'b0, rc, rd, er, seen);
    checks++;
    if (!ok || !seen || rc != g + 1 + TO || er !== 1'b0 || rd !== mem_word(32'h304)) begin
      errors++;
      $display("FAIL timeout_edge_ack: rv@%0d err=%b rdata=%h expected rv@%0d err 0 rdata %h",
               rc, er, rd, g + 1 + TO, mem_word(32'h304));
    end
  endtask

  task automatic test_reset_mid();
    int g, rc, bad;
    bit ok, okr, gnt_now;
    logic [DW-1:0] rd;
    logic er;
    ack_lat = 0;
    bad = 0;
    issue_if(32'h400, g, ok);
    repeat (3) @(posedge clk);
    #1;
    RN = 1'b1;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, rsp_err} !== 7'd0 ||
        rsp_rdata !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: mem_req=%b addr=%h rv=%b expected all zero", mem_req, mem_addr, if_rvalid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if_rvalid !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    ack_lat = 2;
    RN      = 1'b0;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h500;
    dm_be   = 4'hF;
    @(negedge clk);
    gnt_now = (dm_gnt === 1'b1);
    g = cyc;
    @(posedge clk); #1;
    dm_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_rvalid !== 1'b0) bad++;
      if (dm_rvalid === 1'b1) break;
    end
    checks++;
    if (bad != 0 || !ok) begin
      errors++;
      $display("FAIL reset_mid_drop: stray if_rvalid count=%0d expected 0", bad);
    end
    checks++;
    if (!gnt_now) begin
      errors++;
      $display("FAIL reset_first_grant: dm_gnt=%b in first cycle after release expected 1", dm_gnt);
    end
    rc = cyc;
    checks++;
    if (rc != g + 3 || rsp_err !== 1'b0 || rsp_rdata !== mem_word(32'h500)) begin
      errors++;
      $display("FAIL reset_after_txn: rv@%0d err=%b rdata=%h expected rv@%0d err 0 rdata %h",
               rc, rsp_err, rsp_rdata, g + 3, mem_word(32'h500));
    end
    okr = 1'b1;
    rd = '0;
    er = 1'b0;
  endtask

  task automatic test_idle_ack();
    int g, rc, bad, if_g;
    bit ok, okr;
    logic [DW-1:0] rd;
    logic er;
    bad = 0;
    if_g = 0;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_ack: reacting cycles=%0d expected 0", bad);
    end
    ack_lat = 6;
    issue_dm(1'b1, 32'h600, $urandom(), 4'hF, g, ok);
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 32'h700;
    @(negedge clk);
    if (if_gnt === 1'b1) if_g++;
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_rsp(1'b1, rc, rd, er, okr);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_gnt === 1'b1 || if_rvalid === 1'b1) if_g++;
    end
    checks++;
    if (!ok || !okr || if_g != 0 || rc != g + 7) begin
      errors++;
      $display("FAIL abandoned_req: if activity=%0d dm rv@%0d expected 0 and rv@%0d", if_g, rc, g + 7);
    end
  endtask

  task automatic test_random();
    int gi, gd, rci, rcd, mode;
    bit oki, okd, okri, okrd, exp_err;
    logic [DW-1:0] rdi, rdd;
    logic eri, erd;
    for (int n = 0; n < 40; n++) begin
      ack_lat = $urandom_range(0, TO + 2);
      mode    = $urandom_range(0, 2);
      exp_err = !(ack_lat >= 1 && ack_lat <= TO);
      oki = 1'b1; okd = 1'b1; okri = 1'b1; okrd = 1'b1;
      eri = exp_err; erd = exp_err;
      fork
        if (mode != 1) begin
          issue_if($urandom(), gi, oki);
          wait_rsp(1'b0, rci, rdi, eri, okri);
        end
        if (mode != 0) begin
          issue_dm(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)), gd, okd);
          wait_rsp(1'b1, rcd, rdd, erd, okrd);
        end
      join
      checks++;
      if (!oki || !okd || !okri || !okrd || eri !== exp_err || erd !== exp_err) begin
        errors++;
        $display("FAIL random_txn %0d: mode=%0d lat=%0d ok=%b%b%b%b err=%b/%b expected err %b",
                 n, mode, ack_lat, oki, okd, okri, okrd, eri, erd, exp_err);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_store();
    test_contention();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sam_mem_arbiter.md
SAM_MEM_ARBITER -- requirements
Module: sam_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of addresses and data.
REQ-002 SHALL have parameter TIMEOUT, default 15, number of active cycles without mem_ack before the transaction is aborted.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port RN  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_req  in  1  instruction-fetch read request.
REQ-006 SHALL have port if_addr  in  DATA_W  fetch address.
REQ-007 SHALL have port if_gnt  out  1  fetch request accepted.
REQ-008 SHALL have port if_rvalid  out  1  fetch response valid.
REQ-009 SHALL have port dm_req  in  1  data-memory request.
REQ-010 SHALL have port dm_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_addr  in  DATA_W  data address.
REQ-012 SHALL have port dm_wdata  in  DATA_W  store data.
REQ-013 SHALL have port dm_be  in  DATA_W/8  store byte enables.
REQ-014 SHALL have port dm_gnt  out  1  data request accepted.
REQ-015 SHALL have port dm_rvalid  out  1  data response valid (loads and stores).
REQ-016 SHALL have port rsp_rdata  out  DATA_W  shared response data.
REQ-017 SHALL have port rsp_err  out  1  response is a timeout abort.
REQ-018 SHALL have port mem_req  out  1  shared memory request.
REQ-019 SHALL have port mem_we, mem_addr, mem_wdata, mem_be  out  1/DATA_W/DATA_W/DATA_W/8  registered copy of the granted request.
REQ-020 SHALL have port mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-021 SHALL have port mem_ack  in  1  memory completes the current request.

Function
REQ-022 SHALL implement FSM states IDLE, IF_ACT and DM_ACT; at most one transaction outstanding.
REQ-023 SHALL grant only in IDLE: *_gnt is combinational and asserted for one cycle; request fields are captured at that edge; next state is the owner's *_ACT.
REQ-024 SHALL, on IF/DM contention in IDLE, grant DM (fixed priority) unless SAM_ARB_RR_EN is defined.
REQ-025 SHALL drive mem_req=1 with stable captured fields for every *_ACT cycle until mem_ack or timeout.
REQ-026 SHALL, on mem_ack in *_ACT, register mem_rdata (0 for stores) into rsp_rdata, pulse the owner's *_rvalid for exactly one cycle on the next cycle with rsp_err=0, and return to IDLE.
REQ-027 SHALL give a minimum latency of gnt at cycle N, mem_req at N+1, and rvalid at N+2 with zero-wait memory; a new grant SHALL be allowed in the same cycle as rvalid.
REQ-028 SHALL, when TIMEOUT active cycles elapse without mem_ack, drop mem_req, pulse the owner's *_rvalid with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-029 SHALL, when mem_ack coincides with timeout expiry, complete the transaction normally with rsp_err=0.
REQ-030 SHALL ignore mem_ack in IDLE; a request deasserted before grant SHALL leave no state.

Reset
REQ-031 SHALL, on RN=1 at any time including mid-transaction, force IDLE, clear the timer, drop the in-flight transaction without any response, and drive every output to 0.
REQ-032 SHALL accept a grant in the first cycle after RN deasserts.

Configuration
REQ-033 SHALL, when SAM_ARB_RR_EN is defined, keep a last_owner register (reset = DM) and resolve contention to the requester that was not served last; when it is undefined, contention SHALL go to DM and no last_owner register SHALL exist.

Structure
REQ-034 SHALL take the state enum, the owner encoding (OWN_IF, OWN_DM) and the default widths from package sam_arb_pkg.
REQ-035 SHALL place the timeout counter in sub-module sam_arb_timer (inputs: clear, enable; output: expired).

Verification
REQ-036 Load dm_addr=0x100 with mem_ack one cycle after mem_req and mem_rdata=0xDEADBEEF -> dm_rvalid at N+2, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 if_req and dm_req in the same cycle -> dm_gnt first and if_gnt immediately after the DM response; with SAM_ARB_RR_EN, two contention rounds -> IF and DM each served once, IF first.
REQ-038 Store dm_be=4'b0011, dm_wdata=0x1234 -> mem_be=0011 and mem_wdata=0x1234 stable until ack; dm_rvalid follows with rsp_rdata=0.
REQ-039 Memory never acks -> mem_req held 15 cycles, then if_rvalid=1 with rsp_err=1; then mem_ack on cycle 15 -> normal completion, rsp_err=0.
REQ-040 RN=1 during IF_ACT -> all outputs 0 immediately and no if_rvalid; a new request after release is granted in the first cycle.
